// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the MEM stage load/store engine
package mem_access_pkg;

    typedef enum logic [2:0] {
        MA_B  = 3'b000,
        MA_H  = 3'b001,
        MA_W  = 3'b010,
        MA_BU = 3'b100,
        MA_HU = 3'b101
    } ma_width_e;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_XFER = 2'd1,
        MA_DONE = 2'd2
    } ma_state_e;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ma_we;
        logic        ma_re;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] sdata;
    } ex_mem_t;

    // Index of the final byte of a transfer; the 2'b11 size behaves as a word
    function automatic logic [1:0] last_idx(input logic [2:0] width);
        return width[1:0] == 2'b00 ? 2'd0 : width[1:0] == 2'b01 ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: sign/zero-extends the assembled load bytes to 32 bits
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] buf_in,
    input  logic [2:0]  width,
    output logic [31:0] data
);

    logic       sx;
    logic [1:0] li;

    always_comb begin
        sx   = ~width[2];
        li   = last_idx(width);
        data = li == 2'd0 ? {{24{sx & buf_in[7]}}, buf_in[7:0]} :
               li == 2'd1 ? {{16{sx & buf_in[15]}}, buf_in[15:0]} : buf_in;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: EX/MEM register plus byte-serial load/store engine on an 8-bit memory port
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [4:0]        stall,
    input  logic              we_in,
    input  logic [4:0]        waddr_in,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic              ma_we_in,
    input  logic              ma_re_in,
    input  logic [2:0]        ma_width_in,
    input  logic [31:0]       ma_addr_in,
    input  logic [XLEN-1:0]   ma_wdata_in,
    output logic              we,
    output logic [4:0]        waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    ex_mem_t     ex_q, ex_d;
    ma_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] lbuf_q, lbuf_d;
    logic [31:0] load_data;
    logic        op;
    logic        unused_stall;

    assign unused_stall = ^{stall[4], stall[1:0]};

    mem_load_ext u_ext (
        .buf_in (lbuf_q),
        .width  (ex_q.width),
        .data   (load_data)
    );

    always_comb begin
        ex_d = ex_q;
        if (rdy && !stall[3])
            ex_d = stall[2] ? '0 : {we_in, waddr_in, wdata_in, ma_we_in, ma_re_in,
                                    ma_width_in, ma_addr_in, ma_wdata_in};
    end

    always_comb begin
        op        = ex_q.ma_re | ex_q.ma_we;
        state_d   = state_q;
        cnt_d     = cnt_q;
        lbuf_d    = lbuf_q;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (state_q == MA_XFER) begin
            mem_req   = rdy;
            mem_rw    = ex_q.ma_we;
            mem_addr  = ADDR_W'(ex_q.addr + 32'(cnt_q));
            mem_wdata = ex_q.sdata[{cnt_q, 3'b000} +: 8];
        end
        if (rdy) begin
            case (state_q)
                MA_IDLE: if (op) begin
                    state_d = MA_XFER;
                    cnt_d   = 2'd0;
                end
                MA_XFER: if (mem_ack) begin
                    if (ex_q.ma_re) lbuf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_idx(ex_q.width)) state_d = MA_DONE;
                end
                default: state_d = MA_IDLE;
            endcase
        end
        stall_req = op & (state_q != MA_DONE);
        we        = ex_q.we & ~stall_req;
        waddr     = ex_q.waddr;
        wdata     = ex_q.ma_re ? load_data : ex_q.wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            state_q <= MA_IDLE;
            cnt_q   <= 2'd0;
            lbuf_q  <= 32'h0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lbuf_q  <= lbuf_d;
        end
    end

endmodule
